// File: rtl/bus_arbiter_pkg.sv
// Shared bus definitions: arbiter state encoding, master indices and counter width.
package bus_arbiter_pkg;

    typedef enum logic [1:0] {
        BUS_ARB_IDLE   = 2'd0,
        BUS_ARB_ACCESS = 2'd1,
        BUS_ARB_WAIT   = 2'd2,
        BUS_ARB_DONE   = 2'd3
    } bus_arb_state_e;

    localparam int unsigned MASTER_CPU    = 0;
    localparam int unsigned MASTER_VIDEO  = 1;

    // Read latency counter width; covers RD_LATENCY up to 15.
    localparam int unsigned BUS_ARB_CNT_W = 4;

endpackage

// File: rtl/bus_arbiter_rr.sv
// Round-robin winner selection: first requester found scanning from last+1 upward, wrapping.
module rr_picker
    import bus_arbiter_pkg::*;
#(
    parameter  int unsigned N_MASTERS = 2,
    localparam int unsigned IW        = $clog2(N_MASTERS)
) (
    input  logic [N_MASTERS-1:0] req_i,
    input  logic [IW-1:0]        last_i,
    output logic [IW-1:0]        winner_o,
    output logic                 valid_o
);

    always_comb begin
        winner_o = '0;
        valid_o  = 1'b0;
        for (int unsigned k = 1; k <= N_MASTERS; k++) begin
            if (!valid_o && req_i[IW'((32'(last_i) + k) % N_MASTERS)]) begin
                winner_o = IW'((32'(last_i) + k) % N_MASTERS);
                valid_o  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Shared-memory bus arbiter: round-robin grant, single-beat read/write per grant.
// Define BUS_ARB_PRIO0_EN to give master 0 (CPU) absolute priority over the rotating others.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter  int unsigned N_MASTERS  = 2,
    parameter  int unsigned AW         = 16,
    parameter  int unsigned DW         = 8,
    parameter  int unsigned RD_LATENCY = 1,
    localparam int unsigned IW         = $clog2(N_MASTERS)
) (
    input  logic                    sys_clk,
    input  logic                    reset_n,
    input  logic [N_MASTERS-1:0]    m_req,
    input  logic [N_MASTERS-1:0]    m_we,
    input  logic [N_MASTERS*AW-1:0] m_addr,
    input  logic [N_MASTERS*DW-1:0] m_wdata,
    output logic [N_MASTERS-1:0]    m_ack,
    output logic [DW-1:0]           m_rdata,
    output logic [AW-1:0]           mem_addr,
    output logic [DW-1:0]           mem_wdata,
    output logic                    mem_we,
    input  logic [DW-1:0]           mem_rdata,
    output logic [IW-1:0]           grant_id,
    output logic                    busy
);

    localparam int unsigned CW = BUS_ARB_CNT_W;

    bus_arb_state_e       state_q, state_d;
    logic [IW-1:0]        grant_q, grant_d;
    logic [IW-1:0]        last_q, last_d;
    logic                 we_q, we_d;
    logic [AW-1:0]        addr_q, addr_d;
    logic [DW-1:0]        wdata_q, wdata_d;
    logic                 mem_we_q, mem_we_d;
    logic [N_MASTERS-1:0] ack_q, ack_d;
    logic [DW-1:0]        rdata_q, rdata_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 busy_q, busy_d;

    logic [AW-1:0]        addr_a  [N_MASTERS];
    logic [DW-1:0]        wdata_a [N_MASTERS];
    logic [IW-1:0]        pick;
    logic                 pick_valid;
    logic [IW-1:0]        rr_win;
    logic                 rr_valid;

    always_comb begin
        for (int unsigned i = 0; i < N_MASTERS; i++) begin
            addr_a[i]  = m_addr[i*AW +: AW];
            wdata_a[i] = m_wdata[i*DW +: DW];
        end
    end

`ifdef BUS_ARB_PRIO0_EN
    // Rotation among non-CPU masters resumes after the last non-CPU grant.
    logic [IW-1:0]        last_oth_q;
    logic [IW-1:0]        rr_last;
    logic [N_MASTERS-1:0] rr_req;

    always_comb begin
        rr_req             = m_req;
        rr_req[MASTER_CPU] = 1'b0;
    end

    assign rr_last = (last_q == IW'(MASTER_CPU)) ? last_oth_q : last_q;

    always_ff @(posedge sys_clk) begin
        if (!reset_n) begin
            last_oth_q <= IW'(N_MASTERS - 1);
        end else if (state_q == BUS_ARB_DONE && grant_q != IW'(MASTER_CPU)) begin
            last_oth_q <= grant_q;
        end
    end

    rr_picker #(.N_MASTERS(N_MASTERS)) u_picker (
        .req_i    (rr_req),
        .last_i   (rr_last),
        .winner_o (rr_win),
        .valid_o  (rr_valid)
    );

    assign pick_valid = m_req[MASTER_CPU] | rr_valid;
    assign pick       = m_req[MASTER_CPU] ? IW'(MASTER_CPU) : rr_win;
`else
    rr_picker #(.N_MASTERS(N_MASTERS)) u_picker (
        .req_i    (m_req),
        .last_i   (last_q),
        .winner_o (rr_win),
        .valid_o  (rr_valid)
    );

    assign pick_valid = rr_valid;
    assign pick       = rr_win;
`endif

    always_ff @(posedge sys_clk) begin
        if (!reset_n) begin
            state_q  <= BUS_ARB_IDLE;
            grant_q  <= '0;
            last_q   <= IW'(N_MASTERS - 1);
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            mem_we_q <= 1'b0;
            ack_q    <= '0;
            rdata_q  <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            last_q   <= last_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            mem_we_q <= mem_we_d;
            ack_q    <= ack_d;
            rdata_q  <= rdata_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
        end
    end

    // Registered outputs are computed one state ahead so they line up with the state they belong to.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        last_d   = last_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        mem_we_d = 1'b0;
        ack_d    = '0;
        rdata_d  = rdata_q;
        cnt_d    = cnt_q;

        case (state_q)
            BUS_ARB_IDLE: begin
                if (pick_valid) begin
                    state_d  = BUS_ARB_ACCESS;
                    grant_d  = pick;
                    we_d     = m_we[pick];
                    addr_d   = addr_a[pick];
                    wdata_d  = wdata_a[pick];
                    mem_we_d = m_we[pick];
                end
            end
            BUS_ARB_ACCESS: begin
                if (!m_req[grant_q]) begin
                    state_d = BUS_ARB_IDLE;
                end else if (we_q) begin
                    state_d        = BUS_ARB_DONE;
                    ack_d[grant_q] = 1'b1;
                end else begin
                    state_d = BUS_ARB_WAIT;
                    cnt_d   = CW'(RD_LATENCY);
                end
            end
            BUS_ARB_WAIT: begin
                if (!m_req[grant_q]) begin
                    state_d = BUS_ARB_IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_d        = BUS_ARB_DONE;
                        rdata_d        = mem_rdata;
                        ack_d[grant_q] = 1'b1;
                    end
                end
            end
            BUS_ARB_DONE: begin
                state_d = BUS_ARB_IDLE;
                last_d  = grant_q;
            end
            default: state_d = BUS_ARB_IDLE;
        endcase

        busy_d = (state_d != BUS_ARB_IDLE);
    end

    assign m_ack     = ack_q;
    assign m_rdata   = rdata_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_we    = mem_we_q;
    assign grant_id  = grant_q;
    assign busy      = busy_q;

endmodule
